// File: rtl/bsn_pkg.sv
// Shared types and constants for the stochastic bitstream network controller.
// The build macro BSN_DECORRELATE_EN is consumed in bsn_sng.
package bsn_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } bsn_state_t;

   localparam int CTRL_START = 0;
   localparam int CTRL_ABORT = 1;
   localparam int STAT_DONE  = 0;
   localparam int STAT_BUSY  = 1;

   // Maximal-length Fibonacci feedback masks; bit (t-1) set for polynomial tap t.
   function automatic logic [15:0] lfsr_taps(input int width);
      logic [15:0] m;
      case (width)
         3:       m = 16'h0006;
         4:       m = 16'h000C;
         5:       m = 16'h0014;
         6:       m = 16'h0030;
         7:       m = 16'h0060;
         8:       m = 16'h00B8;
         9:       m = 16'h0110;
         10:      m = 16'h0240;
         11:      m = 16'h0500;
         12:      m = 16'h0829;
         13:      m = 16'h100D;
         14:      m = 16'h2015;
         15:      m = 16'h6000;
         16:      m = 16'hD008;
         default: m = 16'h0000;
      endcase
      return m;
   endfunction

endpackage

// File: rtl/bitstream_network_ctrl_if.sv
// Host register and network fabric signals of the bitstream network controller.
interface bitstream_network_ctrl_if #(
   parameter int N_IN   = 2,
   parameter int N_OUT  = 1,
   parameter int DATA_W = 8,
   parameter int CNT_W  = 8
);
   logic [7:0]                   control_in;
   logic [7:0]                   control_out;
   logic [N_IN-1:0][DATA_W-1:0]  data_in;
   logic [N_OUT-1:0][CNT_W-1:0]  data_out;
   logic [N_IN-1:0]              bs_out;
   logic                         bs_valid;
   logic [N_OUT-1:0]             bs_in;

   modport master (
      output control_in, data_in, bs_in,
      input  control_out, data_out, bs_out, bs_valid
   );

   modport slave (
      input  control_in, data_in, bs_in,
      output control_out, data_out, bs_out, bs_valid
   );
endinterface

// File: rtl/bsn_sng.sv
// Stochastic number generators: one shared LFSR and N_IN comparators.
// BSN_DECORRELATE_EN rotates the LFSR value left by (i mod DATA_W) for generator i.
module bsn_sng
   import bsn_pkg::*;
#(
   parameter int N_IN   = 2,
   parameter int DATA_W = 8,
   parameter int SEED   = 1
) (
   input  logic                        clk,
   input  logic                        n_rst,
   input  logic                        load,
   input  logic                        step,
   input  logic [N_IN-1:0][DATA_W-1:0] data,
   output logic [N_IN-1:0]             bs
);
   localparam logic [DATA_W-1:0] TAPS   = DATA_W'(lfsr_taps(DATA_W));
   localparam logic [DATA_W-1:0] SEED_V = DATA_W'(SEED);

   logic [DATA_W-1:0]             lfsr;
   logic [N_IN-1:0][DATA_W-1:0]   word;

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         lfsr <= SEED_V;
         word <= '0;
      end else if (load) begin
         lfsr <= SEED_V;
         word <= data;
      end else if (step) begin
         lfsr <= {lfsr[DATA_W-2:0], ^(lfsr & TAPS)};
      end
   end

   for (genvar i = 0; i < N_IN; i++) begin : g_gen
      logic [DATA_W-1:0] cmp_v;
`ifdef BSN_DECORRELATE_EN
      localparam int ROT = i % DATA_W;
      if (ROT == 0) begin : g_norot
         assign cmp_v = lfsr;
      end else begin : g_rot
         assign cmp_v = {lfsr[DATA_W-1-ROT:0], lfsr[DATA_W-1:DATA_W-ROT]};
      end
`else
      assign cmp_v = lfsr;
`endif
      assign bs[i] = (cmp_v <= word[i]);
   end

endmodule

// File: rtl/bitstream_network_ctrl.sv
// Sequences one stochastic pass through the external network and counts returned ones.
// Optional build macro BSN_DECORRELATE_EN (see bsn_sng) decorrelates generated streams.
//
// state    | meaning
// ST_IDLE  | waiting for start edge, no result published since reset/abort
// ST_RUN   | streaming STREAM_LEN bits, bs_valid high
// ST_DRAIN | network latency plus one settle cycle for the last count
// ST_DONE  | result on data_out, done high until next start
module bitstream_network_ctrl
   import bsn_pkg::*;
#(
   parameter int N_IN       = 2,
   parameter int N_OUT      = 1,
   parameter int DATA_W     = 8,
   parameter int STREAM_LEN = 2**DATA_W - 1,
   parameter int NET_LAT    = 0,
   parameter int SEED       = 1,
   parameter int CNT_W      = $clog2(STREAM_LEN + 1)
) (
   input logic                    clk,
   input logic                    n_rst,
   bitstream_network_ctrl_if.slave bus
);
   localparam int               TMR_W   = $clog2(STREAM_LEN + NET_LAT + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   bsn_state_t                  state;
   logic [TMR_W-1:0]            tmr;
   logic                        start_q;
   logic                        done_q;
   logic                        busy_q;
   logic                        bs_valid_q;
   logic [N_OUT-1:0][CNT_W-1:0] cnt;
   logic [N_OUT-1:0][CNT_W-1:0] result;
   logic [N_IN-1:0]             bs_raw;
   logic                        start_ok;
   logic                        abort;
   logic                        in_pass;
   logic                        clr_pipe;
   logic                        vld_net;
   logic                        unused_ctrl;

   assign abort       = bus.control_in[CTRL_ABORT];
   assign in_pass     = (state == ST_RUN) || (state == ST_DRAIN);
   assign start_ok    = bus.control_in[CTRL_START] & ~start_q & ~abort &
                        ((state == ST_IDLE) || (state == ST_DONE));
   assign clr_pipe    = start_ok | (abort & in_pass);
   assign unused_ctrl = ^bus.control_in[7:2];

   bsn_sng #(
      .N_IN   (N_IN),
      .DATA_W (DATA_W),
      .SEED   (SEED)
   ) u_sng (
      .clk   (clk),
      .n_rst (n_rst),
      .load  (start_ok),
      .step  (state == ST_RUN),
      .data  (bus.data_in),
      .bs    (bs_raw)
   );

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state      <= ST_IDLE;
         tmr        <= '0;
         start_q    <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         bs_valid_q <= 1'b0;
         result     <= '0;
      end else begin
         start_q <= bus.control_in[CTRL_START];
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start_ok) begin
                  state      <= ST_RUN;
                  tmr        <= TMR_W'(STREAM_LEN - 1);
                  done_q     <= 1'b0;
                  busy_q     <= 1'b1;
                  bs_valid_q <= 1'b1;
               end
            end
            ST_RUN: begin
               if (abort) begin
                  state      <= ST_IDLE;
                  busy_q     <= 1'b0;
                  bs_valid_q <= 1'b0;
               end else if (tmr == '0) begin
                  state      <= ST_DRAIN;
                  tmr        <= TMR_W'(NET_LAT);
                  bs_valid_q <= 1'b0;
               end else begin
                  tmr <= tmr - TMR_W'(1);
               end
            end
            ST_DRAIN: begin
               if (abort) begin
                  state  <= ST_IDLE;
                  busy_q <= 1'b0;
               end else if (tmr == '0) begin
                  state  <= ST_DONE;
                  done_q <= 1'b1;
                  busy_q <= 1'b0;
                  result <= cnt;
               end else begin
                  tmr <= tmr - TMR_W'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   // bs_valid aligned to the returning network samples
   if (NET_LAT == 0) begin : g_nolat
      assign vld_net = bs_valid_q;
   end else begin : g_lat
      logic [NET_LAT-1:0] vld_dly;
      always_ff @(posedge clk or negedge n_rst) begin
         if (!n_rst)        vld_dly <= '0;
         else if (clr_pipe) vld_dly <= '0;
         else               vld_dly <= (vld_dly << 1) | NET_LAT'(bs_valid_q);
      end
      assign vld_net = vld_dly[NET_LAT-1];
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         cnt <= '0;
      end else if (start_ok) begin
         cnt <= '0;
      end else if (vld_net && in_pass) begin
         for (int j = 0; j < N_OUT; j++) begin
            if (bus.bs_in[j] && (cnt[j] != CNT_MAX)) cnt[j] <= cnt[j] + CNT_W'(1);
         end
      end
   end

   always_comb begin
      bus.control_out            = '0;
      bus.control_out[STAT_DONE] = done_q;
      bus.control_out[STAT_BUSY] = busy_q;
   end

   assign bus.data_out = result;
   assign bus.bs_valid = bs_valid_q;
   assign bus.bs_out   = bs_raw & {N_IN{bs_valid_q}};

endmodule

// File: tb/tb_bitstream_network_ctrl.sv
// Directed bench: loopback/AND/OR networks on a zero-latency instance, plus a 3-cycle-latency instance.
module tb_bitstream_network_ctrl;
   logic clk = 1'b0;
   logic n_rst = 1'b0;
   always #5 clk = ~clk;

   bitstream_network_ctrl_if #(.N_IN(2), .N_OUT(1), .DATA_W(8), .CNT_W(8)) if0 ();
   bitstream_network_ctrl_if #(.N_IN(2), .N_OUT(1), .DATA_W(8), .CNT_W(8)) if3 ();

   bitstream_network_ctrl #(
      .N_IN(2), .N_OUT(1), .DATA_W(8), .STREAM_LEN(255), .NET_LAT(0), .SEED(1), .CNT_W(8)
   ) dut0 (.clk(clk), .n_rst(n_rst), .bus(if0));

   bitstream_network_ctrl #(
      .N_IN(2), .N_OUT(1), .DATA_W(8), .STREAM_LEN(255), .NET_LAT(3), .SEED(1), .CNT_W(8)
   ) dut3 (.clk(clk), .n_rst(n_rst), .bus(if3));

   // network for dut0: 0 = stream0, 1 = stream1, 2 = AND, 3 = OR
   logic [1:0] net_sel;
   assign if0.bs_in = (net_sel == 2'd0) ? if0.bs_out[0] :
                      (net_sel == 2'd1) ? if0.bs_out[1] :
                      (net_sel == 2'd2) ? (if0.bs_out[0] & if0.bs_out[1]) :
                                          (if0.bs_out[0] | if0.bs_out[1]);

   logic [2:0] dly3;
   always @(posedge clk or negedge n_rst) begin
      if (!n_rst) dly3 <= 3'b000;
      else        dly3 <= {dly3[1:0], if3.bs_out[1]};
   end
   assign if3.bs_in = dly3[2];

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual %0d required %0d", name, act, exp);
      end
   endtask

   typedef struct {
      logic [7:0] d0;
      logic [7:0] d1;
      logic [1:0] sel;
      bit         retrig;
      int         exp;
   } vec_t;
   vec_t vecs[10];

   task automatic start0(input logic [7:0] d0, input logic [7:0] d1, input logic [1:0] sel,
                         input bit hold);
      net_sel            = sel;
      if0.data_in[0]     = d0;
      if0.data_in[1]     = d1;
      if0.control_in[0]  = 1'b1;
      @(posedge clk); #1;
      if (!hold) if0.control_in[0] = 1'b0;
      if0.data_in[0] = ~d0;
      if0.data_in[1] = ~d1;
      chk("ctl_after_start", if0.control_out, 8'h02);
   endtask

   task automatic wait0(input bit retrig, output int cyc, output int vcnt);
      cyc  = 0;
      vcnt = (if0.bs_valid === 1'b1) ? 1 : 0;
      while (if0.control_out[0] !== 1'b1 && cyc < 1000) begin
         @(posedge clk); #1;
         cyc++;
         if (retrig && cyc == 10) if0.control_in[0] = 1'b1;
         if (retrig && cyc == 11) if0.control_in[0] = 1'b0;
         if (if0.bs_valid === 1'b1) vcnt++;
      end
   endtask

   initial begin
      int cyc;
      int vcnt;

      vecs[0] = '{8'd22,  8'd210, 2'd0, 1'b0, 22};
      vecs[1] = '{8'd22,  8'd210, 2'd1, 1'b0, 210};
      vecs[2] = '{8'd22,  8'd210, 2'd2, 1'b0, 22};
      vecs[3] = '{8'd22,  8'd210, 2'd3, 1'b0, 210};
      vecs[4] = '{8'd0,   8'd255, 2'd0, 1'b1, 0};
      vecs[5] = '{8'd0,   8'd255, 2'd1, 1'b0, 255};
      vecs[6] = '{8'd1,   8'd0,   2'd2, 1'b0, 0};
      vecs[7] = '{8'd1,   8'd0,   2'd3, 1'b0, 1};
      vecs[8] = '{8'd100, 8'd37,  2'd3, 1'b1, 100};
      vecs[9] = '{8'd128, 8'd128, 2'd2, 1'b0, 128};

      if0.control_in = '0;
      if0.data_in    = '0;
      if3.control_in = '0;
      if3.data_in    = '0;
      net_sel        = 2'd0;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_ctl", if0.control_out, 8'h00);
      chk("rst_dout", if0.data_out, 0);
      chk("rst_valid", if0.bs_valid, 0);
      chk("rst_bsout", if0.bs_out, 0);
      chk("rst_ctl3", if3.control_out, 8'h00);
      n_rst = 1'b1;
      @(posedge clk); #1;

      for (int i = 0; i < 10; i++) begin
         start0(vecs[i].d0, vecs[i].d1, vecs[i].sel, 1'b0);
         wait0(vecs[i].retrig, cyc, vcnt);
         chk($sformatf("vec%0d_dout", i), if0.data_out, vecs[i].exp);
         chk($sformatf("vec%0d_ctl", i), if0.control_out, 8'h01);
         chk($sformatf("vec%0d_cycles", i), cyc, 256);
         chk($sformatf("vec%0d_validlen", i), vcnt, 255);
         chk($sformatf("vec%0d_valid_off", i), if0.bs_valid, 0);
         repeat (2) @(posedge clk);
         #1;
      end

      // abort 100 cycles into RUN
      start0(8'd50, 8'd60, 2'd0, 1'b0);
      repeat (100) @(posedge clk);
      #1;
      chk("abort_pre_busy", if0.control_out, 8'h02);
      if0.control_in[1] = 1'b1;
      @(posedge clk); #1;
      chk("abort_ctl", if0.control_out, 8'h00);
      chk("abort_valid", if0.bs_valid, 0);
      chk("abort_bsout", if0.bs_out, 0);
      chk("abort_dout", if0.data_out, 128);
      if0.control_in[1] = 1'b0;
      repeat (300) @(posedge clk);
      #1;
      chk("abort_idle_ctl", if0.control_out, 8'h00);
      chk("abort_idle_dout", if0.data_out, 128);

      // start held high: single run only
      start0(8'd77, 8'd5, 2'd0, 1'b1);
      wait0(1'b0, cyc, vcnt);
      chk("hold_dout", if0.data_out, 77);
      chk("hold_cycles", cyc, 256);
      repeat (20) @(posedge clk);
      #1;
      chk("hold_no_retrig_ctl", if0.control_out, 8'h01);
      chk("hold_no_retrig_valid", if0.bs_valid, 0);
      if0.control_in[0] = 1'b0;
      @(posedge clk); #1;
      start0(8'd33, 8'd5, 2'd0, 1'b0);
      wait0(1'b0, cyc, vcnt);
      chk("rerun_dout", if0.data_out, 33);
      chk("rerun_cycles", cyc, 256);

      // reset pulse mid-run
      start0(8'd40, 8'd90, 2'd1, 1'b0);
      repeat (50) @(posedge clk);
      #1;
      n_rst = 1'b0;
      #1;
      chk("midrst_ctl", if0.control_out, 8'h00);
      chk("midrst_dout", if0.data_out, 0);
      chk("midrst_valid", if0.bs_valid, 0);
      chk("midrst_bsout", if0.bs_out, 0);
      @(posedge clk); #1;
      n_rst = 1'b1;
      @(posedge clk); #1;
      start0(8'd200, 8'd9, 2'd0, 1'b0);
      wait0(1'b0, cyc, vcnt);
      chk("postrst_dout", if0.data_out, 200);
      chk("postrst_ctl", if0.control_out, 8'h01);
      chk("postrst_cycles", cyc, 256);

      // NET_LAT=3 instance, loopback of stream 1 through a 3-stage pipe
      if3.data_in[0]    = 8'd22;
      if3.data_in[1]    = 8'd210;
      if3.control_in[0] = 1'b1;
      @(posedge clk); #1;
      if3.control_in[0] = 1'b0;
      if3.data_in       = '0;
      chk("lat3_ctl_after_start", if3.control_out, 8'h02);
      cyc = 0;
      while (if3.control_out[0] !== 1'b1 && cyc < 1000) begin
         @(posedge clk); #1;
         cyc++;
      end
      chk("lat3_cycles", cyc, 259);
      chk("lat3_dout", if3.data_out, 210);
      chk("lat3_ctl", if3.control_out, 8'h01);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
